sys_ctrl_rx_cmd_decoder: RTL and testbench
==========================================

// Module: sys_ctrl_rx_cmd_decoder
// PURPOSE
//  Parametrised system-controller receive-side command decoder between UART RX and the reg-file/ALU.
//  Parses multi-frame commands into reg-file write/read strobes and ALU operand loads/execute.
//  Adds over the previous generation: N ALU operands, inter-frame timeout, RX frame-error abort, error reporting.
// PARAMETERS
//  FRAME_W        8    width of one RX frame / reg-file data word
//  ADDR_W         4    reg-file address width (<= FRAME_W)
//  ALU_FUN_W      4    ALU function code width (<= FRAME_W)
//  N_OPERANDS     2    operands per ALU command (1..8), written to OPERAND_BASE..OPERAND_BASE+N_OPERANDS-1
//  OPERAND_BASE   0    reg-file address of operand 0
//  TIMEOUT_CYCLES 1024 max idle CLK cycles between frames of one command; 0 = timeout disabled
// PORTS
//  CLK         in   1          system clock
//  rst_n       in   1          async active-low reset
//  RX_P_DATA   in   FRAME_W    received frame, valid when RX_D_VLD=1
//  RX_D_VLD    in   1          one-cycle frame-valid strobe
//  RX_ERR      in   1          parity/stop error, qualifies RX_D_VLD frame
//  WrEn        out  1          reg-file write strobe (1 cycle)
//  RdEn        out  1          reg-file read strobe (1 cycle)
//  Address     out  ADDR_W     reg-file address
//  WrData      out  FRAME_W    reg-file write data
//  ALU_EN      out  1          ALU execute strobe (1 cycle)
//  ALU_FUN     out  ALU_FUN_W  ALU function code
//  Gate_en     out  1          ALU clock-gate enable
//  CLK_Div_EN  out  1          clock-divider enable
//  Busy        out  1          command in progress (state != IDLE)
//  Cmd_Err     out  1          error strobe (1 cycle)
//  Err_Code    out  2          last error: 0 none,1 bad opcode,2 frame err,3 timeout; held until next error
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, operand index 0, timeout counter 0; CLK_Div_EN=1 from first clock edge after reset.
//  Frame "accepted" = RX_D_VLD=1 & RX_ERR=0. All outputs registered; strobes assert the cycle after the completing frame.
//  Opcodes: 0xAA WR (addr,data), 0xBB RD (addr), 0xCC ALU (N_OPERANDS operands, func), 0xDD ALU_NOP (func).
//  Opcodes compare the full 8-bit value; when FRAME_W>8 upper bits must be 0.
//  States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPND, FUNC.
//   IDLE:  AA->WR_ADDR, BB->RD_ADDR, CC->OPND (idx=0), DD->FUNC with Gate_en<=1.
//          Other value -> stay, Cmd_Err, Err_Code=1. RX_ERR frames ignored, no error.
//   WR_ADDR: accept -> Address<=frame[ADDR_W-1:0], ->WR_DATA.
//   WR_DATA: accept -> WrData<=frame, WrEn pulse, ->IDLE.
//   RD_ADDR: accept -> Address<=frame[ADDR_W-1:0], RdEn pulse, ->IDLE.
//   OPND: accept -> WrData<=frame, Address<=OPERAND_BASE+idx (mod 2^ADDR_W), WrEn pulse.
//         idx==N_OPERANDS-1 -> Gate_en<=1, ->FUNC; else idx++.
//   FUNC: accept -> ALU_FUN<=frame[ALU_FUN_W-1:0], ALU_EN pulse, ->IDLE. Gate_en stays 1 through ALU_EN cycle, 0 next cycle.
//  Address/WrData/ALU_FUN hold their last value otherwise.
//  Timeout: counter clears on every accepted frame and in IDLE, increments each non-IDLE cycle without RX_D_VLD.
//   On reaching TIMEOUT_CYCLES -> Cmd_Err, Err_Code=3, ->IDLE, Gate_en<=0, no WrEn/RdEn/ALU_EN.
//  RX_ERR with RX_D_VLD in any non-IDLE state -> abort: Cmd_Err, Err_Code=2, ->IDLE, Gate_en<=0.
//  A frame arriving in the same cycle the timeout expires wins; the counter clears.
//  Back-to-back frames (RX_D_VLD every cycle) must be accepted without loss.
//  Operand writes already issued before an abort are not undone.
//  Reset mid-command returns to IDLE immediately with all outputs 0, except CLK_Div_EN.
// STRUCTURE
//  sys_ctrl_pkg: opcode localparams, state encoding, Err_Code values.
//  Sub-module sys_ctrl_timeout_cnt: counter width $clog2(TIMEOUT_CYCLES+1); clear/enable in, expire out; tied off when TIMEOUT_CYCLES=0.
// TESTING
//  AA,05,3C back-to-back -> one-cycle WrEn with Address=5, WrData=0x3C, the cycle after the 3C frame; Busy low after.
//  BB,0A -> RdEn pulse with Address=0xA; no WrEn.
//  N_OPERANDS=3: CC,11,22,33,02 -> WrEn at addr 0,1,2 with data 11,22,33; Gate_en=1 from after 33 through ALU_EN; ALU_FUN=2.
//  DD,07 -> Gate_en=1, then ALU_EN with ALU_FUN=7; Gate_en=0 cycle after ALU_EN.
//  TIMEOUT_CYCLES=16: AA then silence -> Cmd_Err at 16th idle cycle, Err_Code=3, IDLE; next AA,01,FF writes normally.
//  Bad opcode 0x55 -> Err_Code=1. AA then RX_ERR frame -> Err_Code=2, no WrEn. Reset asserted in OPND -> all outputs 0.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg
//   Shared definitions for the system-controller receive-side command decoder.
//   Contents:
//     OP_*        8-bit command opcodes (compared on the low byte of a frame)
//     state_e     decoder FSM state encoding
//     ERR_*       values reported on Err_Code
package sys_ctrl_pkg;

  localparam logic [7:0] OP_WR      = 8'hAA;  // WR: addr, data
  localparam logic [7:0] OP_RD      = 8'hBB;  // RD: addr
  localparam logic [7:0] OP_ALU     = 8'hCC;  // ALU: N operands, func
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;  // ALU without operands: func

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_OPND    = 3'd4,
    ST_FUNC    = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_FRAME   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/sys_ctrl_timeout_cnt.sv
// sys_ctrl_timeout_cnt
//   Inter-frame idle counter. Counts enabled cycles since the last clear and
//   flags the cycle that completes TIMEOUT_CYCLES idle cycles.
//   Ports:
//     CLK     in   system clock
//     rst_n   in   asynchronous active-low reset
//     clear   in   restart the count (has priority over enable)
//     enable  in   count this cycle
//     expire  out  this enabled cycle is the TIMEOUT_CYCLES-th idle cycle
//   TIMEOUT_CYCLES = 0 disables the counter entirely (expire tied low).
module sys_ctrl_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = &{1'b0, CLK, rst_n, clear, enable};
    assign expire        = 1'b0;
  end else begin : g_on
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturate at TIMEOUT_CYCLES; the owner leaves the busy state on expiry,
    // so the count is cleared on the following cycle anyway.
    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Fires during the idle cycle that would bring the count to TIMEOUT_CYCLES.
    assign expire = enable && !clear && (cnt_q == CNT_LAST);
  end

endmodule

// File: rtl/sys_ctrl_rx_cmd_decoder.sv
// sys_ctrl_rx_cmd_decoder
//   Receive-side command decoder between UART RX and the reg-file / ALU.
//   Parses multi-frame commands (WR, RD, ALU with N operands, ALU_NOP) into
//   one-cycle reg-file and ALU strobes, with inter-frame timeout, abort on
//   RX frame error and error reporting.
//   Ports:
//     CLK, rst_n      clock, asynchronous active-low reset
//     RX_P_DATA       received frame, qualified by RX_D_VLD
//     RX_D_VLD        one-cycle frame strobe
//     RX_ERR          parity/stop error on the RX_D_VLD frame
//     WrEn, RdEn      reg-file write / read strobes
//     Address, WrData reg-file address and write data (held between commands)
//     ALU_EN, ALU_FUN ALU execute strobe and function code
//     Gate_en         ALU clock-gate enable
//     CLK_Div_EN      clock-divider enable (1 from the first edge after reset)
//     Busy            a command is in progress
//     Cmd_Err         error strobe; Err_Code holds the last error cause
//   All outputs are registered: strobes appear the cycle after the frame
//   that completes a command.
module sys_ctrl_rx_cmd_decoder
  import sys_ctrl_pkg::*;
#(
  parameter int FRAME_W        = 8,
  parameter int ADDR_W         = 4,
  parameter int ALU_FUN_W      = 4,
  parameter int N_OPERANDS     = 2,
  parameter int OPERAND_BASE   = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic [FRAME_W-1:0]   RX_P_DATA,
  input  logic                 RX_D_VLD,
  input  logic                 RX_ERR,
  output logic                 WrEn,
  output logic                 RdEn,
  output logic [ADDR_W-1:0]    Address,
  output logic [FRAME_W-1:0]   WrData,
  output logic                 ALU_EN,
  output logic [ALU_FUN_W-1:0] ALU_FUN,
  output logic                 Gate_en,
  output logic                 CLK_Div_EN,
  output logic                 Busy,
  output logic                 Cmd_Err,
  output logic [1:0]           Err_Code
);

  localparam int IDX_W = (N_OPERANDS > 1) ? $clog2(N_OPERANDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OPERANDS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [FRAME_W-1:0]   wr_data_q, wr_data_d;
  logic [ALU_FUN_W-1:0] alu_fun_q, alu_fun_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;
  logic                 alu_en_q, alu_en_d;
  logic                 gate_en_q, gate_en_d;
  logic                 cmd_err_q, cmd_err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic                 clk_div_en_q;

  logic                 frame_acc;
  logic [7:0]           op_byte;
  logic                 op_upper_zero;
  logic [ADDR_W-1:0]    opnd_addr;
  logic                 tmo_clear;
  logic                 tmo_enable;
  logic                 tmo_expire;

  assign frame_acc = RX_D_VLD && !RX_ERR;
  assign op_byte   = RX_P_DATA[7:0];

  // Opcodes are 8-bit values; any set bit above them makes the frame a bad opcode.
  if (FRAME_W > 8) begin : g_wide_frame
    assign op_upper_zero = ~|RX_P_DATA[FRAME_W-1:8];
  end else begin : g_byte_frame
    assign op_upper_zero = 1'b1;
  end

  // Operand n lands at OPERAND_BASE+n, wrapping within the reg-file.
  assign opnd_addr = ADDR_W'(OPERAND_BASE + 32'(idx_q));

  // Count only idle cycles inside a command; any frame (good or bad) stops it.
  assign tmo_clear  = (state_q == ST_IDLE) || frame_acc;
  assign tmo_enable = (state_q != ST_IDLE) && !RX_D_VLD;

  sys_ctrl_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    alu_fun_d  = alu_fun_q;
    gate_en_d  = gate_en_q;
    err_code_d = err_code_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    cmd_err_d  = 1'b0;

    if ((state_q != ST_IDLE) && RX_D_VLD && RX_ERR) begin
      // Corrupted frame mid-command: drop the command.
      state_d    = ST_IDLE;
      gate_en_d  = 1'b0;
      cmd_err_d  = 1'b1;
      err_code_d = ERR_FRAME;
    end else if (tmo_expire) begin
      state_d    = ST_IDLE;
      gate_en_d  = 1'b0;
      cmd_err_d  = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Gate_en covers the ALU_EN cycle only, unless a new ALU_NOP starts now.
          gate_en_d = 1'b0;
          if (frame_acc) begin
            if (!op_upper_zero) begin
              cmd_err_d  = 1'b1;
              err_code_d = ERR_OPCODE;
            end else begin
              case (op_byte)
                OP_WR:  state_d = ST_WR_ADDR;
                OP_RD:  state_d = ST_RD_ADDR;
                OP_ALU: begin
                  state_d = ST_OPND;
                  idx_d   = '0;
                end
                OP_ALU_NOP: begin
                  state_d   = ST_FUNC;
                  gate_en_d = 1'b1;
                end
                default: begin
                  cmd_err_d  = 1'b1;
                  err_code_d = ERR_OPCODE;
                end
              endcase
            end
          end
        end

        ST_WR_ADDR: begin
          if (frame_acc) begin
            addr_d  = RX_P_DATA[ADDR_W-1:0];
            state_d = ST_WR_DATA;
          end
        end

        ST_WR_DATA: begin
          if (frame_acc) begin
            wr_data_d = RX_P_DATA;
            wr_en_d   = 1'b1;
            state_d   = ST_IDLE;
          end
        end

        ST_RD_ADDR: begin
          if (frame_acc) begin
            addr_d  = RX_P_DATA[ADDR_W-1:0];
            rd_en_d = 1'b1;
            state_d = ST_IDLE;
          end
        end

        ST_OPND: begin
          if (frame_acc) begin
            wr_data_d = RX_P_DATA;
            addr_d    = opnd_addr;
            wr_en_d   = 1'b1;
            if (idx_q == IDX_LAST) begin
              gate_en_d = 1'b1;
              state_d   = ST_FUNC;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end

        ST_FUNC: begin
          if (frame_acc) begin
            alu_fun_d = RX_P_DATA[ALU_FUN_W-1:0];
            alu_en_d  = 1'b1;
            state_d   = ST_IDLE;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          gate_en_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      alu_fun_q    <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      alu_en_q     <= 1'b0;
      gate_en_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
      err_code_q   <= ERR_NONE;
      clk_div_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      alu_fun_q    <= alu_fun_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      alu_en_q     <= alu_en_d;
      gate_en_q    <= gate_en_d;
      cmd_err_q    <= cmd_err_d;
      err_code_q   <= err_code_d;
      clk_div_en_q <= 1'b1;
    end
  end

  assign WrEn       = wr_en_q;
  assign RdEn       = rd_en_q;
  assign Address    = addr_q;
  assign WrData     = wr_data_q;
  assign ALU_EN     = alu_en_q;
  assign ALU_FUN    = alu_fun_q;
  assign Gate_en    = gate_en_q;
  assign CLK_Div_EN = clk_div_en_q;
  assign Busy       = (state_q != ST_IDLE);
  assign Cmd_Err    = cmd_err_q;
  assign Err_Code   = err_code_q;

endmodule

// File: tb/tb_sys_ctrl_rx_cmd_decoder.sv
// Testbench for sys_ctrl_rx_cmd_decoder (N_OPERANDS=3, TIMEOUT_CYCLES=16).
// Stimulus feeds a command-level reference model one cycle at a time; the
// model queues the strobe events it predicts, and a monitor on the falling
// edge pops and compares one event per observed strobe.
module tb_sys_ctrl_rx_cmd_decoder;

  localparam int FRAME_W   = 8;
  localparam int ADDR_W    = 4;
  localparam int ALU_FUN_W = 4;
  localparam int N_OPND    = 3;
  localparam int OPND_BASE = 0;
  localparam int TMO       = 16;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_ALU = 2;
  localparam int K_ERR = 3;

  logic                 CLK = 1'b0;
  logic                 rst_n = 1'b0;
  logic [FRAME_W-1:0]   RX_P_DATA = '0;
  logic                 RX_D_VLD = 1'b0;
  logic                 RX_ERR = 1'b0;
  logic                 WrEn, RdEn, ALU_EN, Gate_en, CLK_Div_EN, Busy, Cmd_Err;
  logic [ADDR_W-1:0]    Address;
  logic [FRAME_W-1:0]   WrData;
  logic [ALU_FUN_W-1:0] ALU_FUN;
  logic [1:0]           Err_Code;

  sys_ctrl_rx_cmd_decoder #(
    .FRAME_W(FRAME_W), .ADDR_W(ADDR_W), .ALU_FUN_W(ALU_FUN_W),
    .N_OPERANDS(N_OPND), .OPERAND_BASE(OPND_BASE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RX_ERR(RX_ERR), .WrEn(WrEn), .RdEn(RdEn), .Address(Address),
    .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .Gate_en(Gate_en),
    .CLK_Div_EN(CLK_Div_EN), .Busy(Busy), .Cmd_Err(Cmd_Err), .Err_Code(Err_Code)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int kind;
    int addr;
    int data;
    int func;
    int gate;
    int busy;
    int err_code;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Reference model: the command being collected and its frames so far.
  int  m_cmd = -1;
  int  m_frames[$];
  int  m_idle = 0;
  int  m_err_code = 0;

  function automatic void push_ev(int kind, int addr, int data, int func, int gate, int busy);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.func = func;
    e.gate = gate; e.busy = busy; e.err_code = m_err_code;
    exp_q.push_back(e);
  endfunction

  function automatic void push_err(int code);
    m_err_code = code;
    push_ev(K_ERR, 0, 0, 0, 0, 0);
  endfunction

  function automatic void model_reset();
    m_cmd = -1;
    m_frames.delete();
    m_idle = 0;
    m_err_code = 0;
  endfunction

  // One clock cycle of input as seen by the decoder.
  function automatic void model_step(bit vld, bit err, int data);
    int n;
    if (m_cmd < 0) begin
      if (vld && !err) begin
        if (data == 'hAA || data == 'hBB || data == 'hCC || data == 'hDD) begin
          m_cmd = data;
          m_frames.delete();
          m_idle = 0;
        end else begin
          push_err(1);
        end
      end
    end else if (vld && err) begin
      push_err(2);
      m_cmd = -1;
    end else if (vld) begin
      m_idle = 0;
      m_frames.push_back(data);
      n = m_frames.size();
      case (m_cmd)
        'hAA: if (n == 2) begin
          push_ev(K_WR, m_frames[0] % 16, m_frames[1], 0, 0, 0);
          m_cmd = -1;
        end
        'hBB: begin
          push_ev(K_RD, data % 16, 0, 0, 0, 0);
          m_cmd = -1;
        end
        'hCC: if (n <= N_OPND) begin
          push_ev(K_WR, (OPND_BASE + n - 1) % 16, data, 0, (n == N_OPND) ? 1 : 0, 1);
        end else begin
          push_ev(K_ALU, 0, 0, data % 16, 1, 0);
          m_cmd = -1;
        end
        default: begin
          push_ev(K_ALU, 0, 0, data % 16, 1, 0);
          m_cmd = -1;
        end
      endcase
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        push_err(3);
        m_cmd = -1;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic cyc(input bit vld, input bit err, input int data);
    RX_D_VLD  = vld;
    RX_ERR    = err;
    RX_P_DATA = FRAME_W'(data);
    model_step(vld, err, data);
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int data);
    cyc(1'b1, 1'b0, data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, int'($urandom_range(0, 255)));
  endtask

  function automatic int rand_gap();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 55) return 0;
    if (r < 96) return int'($urandom_range(1, 3));
    return int'($urandom_range(TMO - 2, TMO + 2));
  endfunction

  task automatic rand_cmd();
    int frames[$];
    int sel;
    int b;
    sel = int'($urandom_range(0, 11));
    case (sel)
      0, 1, 2: frames = '{'hAA, int'($urandom_range(0, 255)), int'($urandom_range(0, 255))};
      3, 4:    frames = '{'hBB, int'($urandom_range(0, 255))};
      5, 6, 7: frames = '{'hCC, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 255))};
      8, 9:    frames = '{'hDD, int'($urandom_range(0, 255))};
      10: begin
        do b = int'($urandom_range(0, 255));
        while (b == 'hAA || b == 'hBB || b == 'hCC || b == 'hDD);
        frames = '{b};
      end
      default: frames = '{};
    endcase
    if (frames.size() == 0) begin
      cyc(1'b1, 1'b1, int'($urandom_range(0, 255)));
    end
    foreach (frames[i]) begin
      idle(rand_gap());
      if ($urandom_range(0, 99) < 4) cyc(1'b1, 1'b1, frames[i]);
      else send(frames[i]);
    end
  endtask

  // Scoreboard monitor: one transaction per observed strobe.
  always @(negedge CLK) begin : mon
    int  ones;
    int  act_kind;
    bit  ok;
    ev_t e;
    if (rst_n && (WrEn || RdEn || ALU_EN || Cmd_Err)) begin
      vectors++;
      ones = int'(WrEn) + int'(RdEn) + int'(ALU_EN) + int'(Cmd_Err);
      act_kind = WrEn ? K_WR : RdEn ? K_RD : ALU_EN ? K_ALU : K_ERR;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe t=%0t: got kind=%0d addr=%0h data=%0h fun=%0h ec=%0d required no strobe",
                 $time, act_kind, Address, WrData, ALU_FUN, Err_Code);
      end else begin
        e = exp_q.pop_front();
        ok = (ones == 1) && (act_kind == e.kind) && (int'(Gate_en) == e.gate) &&
             (int'(Busy) == e.busy) && (int'(Err_Code) == e.err_code);
        if (e.kind == K_WR) ok = ok && (int'(Address) == e.addr) && (int'(WrData) == e.data);
        if (e.kind == K_RD) ok = ok && (int'(Address) == e.addr);
        if (e.kind == K_ALU) ok = ok && (int'(ALU_FUN) == e.func);
        if (!ok) begin
          miscompares++;
          $display("FAIL txn t=%0t: got kind=%0d(n=%0d) addr=%0h data=%0h fun=%0h gate=%0b busy=%0b ec=%0d required kind=%0d addr=%0h data=%0h fun=%0h gate=%0d busy=%0d ec=%0d",
                   $time, act_kind, ones, Address, WrData, ALU_FUN, Gate_en, Busy, Err_Code,
                   e.kind, e.addr, e.data, e.func, e.gate, e.busy, e.err_code);
        end else begin
          $display("txn t=%0t kind=%0d addr=%0h data=%0h fun=%0h gate=%0b busy=%0b ec=%0d",
                   $time, act_kind, Address, WrData, ALU_FUN, Gate_en, Busy, Err_Code);
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_strobes", {WrEn, RdEn, ALU_EN, Cmd_Err}, 4'b0000);
    check("rst_levels", {Gate_en, Busy, CLK_Div_EN}, 3'b000);
    check("rst_address", Address, 0);
    check("rst_wrdata_fun_ec", {WrData, ALU_FUN, Err_Code}, 0);
    #4 rst_n = 1'b1;
    @(posedge CLK);
    #1;
    check("clk_div_en_after_rst", CLK_Div_EN, 1);

    // WR back-to-back
    send('hAA); send('h05); send('h3C);
    check("wr_wren", WrEn, 1);
    check("wr_addr_data", {Address, WrData}, {4'h5, 8'h3C});
    idle(1);
    check("wr_pulse_one_cycle", {WrEn, Busy}, 2'b00);

    // RD
    send('hBB); send('h0A);
    check("rd_rden_no_wren", {RdEn, WrEn, Address}, {1'b1, 1'b0, 4'hA});
    idle(2);

    // ALU with three operands
    send('hCC); send('h11); send('h22); send('h33);
    check("alu_gate_after_last_opnd", Gate_en, 1);
    send('h02);
    check("alu_en_fun", {ALU_EN, Gate_en, ALU_FUN}, {1'b1, 1'b1, 4'h2});
    idle(2);

    // ALU_NOP
    send('hDD);
    idle(1);
    check("nop_gate_before_func", Gate_en, 1);
    send('h07);
    check("nop_alu_en", {ALU_EN, Gate_en, ALU_FUN}, {1'b1, 1'b1, 4'h7});
    idle(1);
    check("nop_gate_drops", {ALU_EN, Gate_en}, 2'b00);

    // Timeout after AA, then a normal write
    send('hAA);
    idle(TMO - 1);
    check("tmo_not_yet", {Cmd_Err, Busy}, 2'b01);
    idle(1);
    check("tmo_fires", {Cmd_Err, Busy, Err_Code}, {1'b1, 1'b0, 2'd3});
    idle(3);
    send('hAA); send('h01); send('hFF);
    idle(2);

    // Bad opcode, frame-error abort, errored frame in IDLE ignored
    send('h55);
    idle(1);
    check("bad_opcode_ec", Err_Code, 1);
    send('hAA); cyc(1'b1, 1'b1, 'h07);
    check("frame_err_abort", {Cmd_Err, WrEn, Err_Code}, {1'b1, 1'b0, 2'd2});
    cyc(1'b1, 1'b1, 'h42);
    idle(1);
    check("idle_rx_err_ignored", {Cmd_Err, Busy, Err_Code}, {1'b0, 1'b0, 2'd2});

    // Reset while collecting ALU operands
    send('hCC); send('h11);
    idle(2);
    check("opnd_busy", Busy, 1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_outputs", {WrEn, RdEn, ALU_EN, Cmd_Err, Gate_en, Busy}, 6'b0);
    check("mid_rst_regs", {Address, WrData, ALU_FUN, Err_Code}, 0);
    check("mid_rst_queue_empty", exp_q.size(), 0);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge CLK);
    #1;
    check("clk_div_en_after_mid_rst", CLK_Div_EN, 1);

    // Randomized command stream
    for (int n = 0; n < 300; n++) rand_cmd();

    idle(TMO + 6);
    check("drain_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
